// File: rtl/ahb_slave_arbiter.sv
// rtl/ahb_slave_arbiter.sv - per-slave round-robin AHB arbiter with burst hold
// Optional: AHB_ARB_BURST_LIMIT_EN caps undefined-length INCR ownership at MAX_HOLD beats.
module ahb_slave_arbiter #(
  parameter int SLAVE_X_MASTER_NUM = 3,
  parameter int MASTER_IDX_W       = $clog2(SLAVE_X_MASTER_NUM),
  parameter int MAX_HOLD           = 16
) (
  input  logic                            hclk,
  input  logic                            hreset,
  input  logic [SLAVE_X_MASTER_NUM-1:0]   hreq,
  input  logic [2*SLAVE_X_MASTER_NUM-1:0] htrans,
  input  logic [3*SLAVE_X_MASTER_NUM-1:0] hburst,
  input  logic                            hready,
  output logic [SLAVE_X_MASTER_NUM-1:0]   hgrant,
  output logic [MASTER_IDX_W-1:0]         hmaster_addr,
  output logic                            hsel,
  output logic [MASTER_IDX_W-1:0]         hmaster_data,
  output logic                            hdata_valid
);
  localparam int N = SLAVE_X_MASTER_NUM;
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_OWN  = 1'b1;
  localparam logic [1:0] TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'b000, BU_INCR = 3'b001;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  if (SLAVE_X_MASTER_NUM < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("ahb_slave_arbiter: SLAVE_X_MASTER_NUM must be >= 2 and MAX_HOLD >= 1");
  end

  logic [0:0]              state;
  logic [MASTER_IDX_W-1:0] last_owner;
  logic [3:0]              beat_cnt, beat_nxt;
  logic                    own_req, rearb, incr_beat;
  logic [1:0]              own_trans;
  logic [2:0]              own_burst;
  logic                    hi_found, lo_found;
  logic [MASTER_IDX_W-1:0] hi_idx, lo_idx, win_idx;

  always_comb begin
    own_req   = 1'b0;
    own_trans = TR_IDLE;
    own_burst = BU_SINGLE;
    for (int j = 0; j < N; j++) begin
      if (hmaster_addr == MASTER_IDX_W'(j)) begin
        own_req   = hreq[j];
        own_trans = htrans[2*j +: 2];
        own_burst = hburst[3*j +: 3];
      end
    end
  end

  // Round robin: first requester above last_owner, else lowest requester (wraps to last_owner itself).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (hreq[j] && !hi_found && j > int'(last_owner)) begin
        hi_found = 1'b1;
        hi_idx   = MASTER_IDX_W'(j);
      end
      if (hreq[j] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = MASTER_IDX_W'(j);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  assign hsel = (state == ARB_OWN) && own_req;

`ifdef AHB_ARB_BURST_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic              limit_hit;
  assign limit_hit = incr_beat && (hold_cnt >= HOLD_LAST) && |(hreq & ~hgrant);
`else
  logic limit_hit;
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    beat_nxt  = beat_cnt;
    rearb     = 1'b0;
    incr_beat = 1'b0;
    if (state == ARB_IDLE || !own_req || own_trans == TR_IDLE) begin
      rearb = 1'b1;
    end else begin
      case (own_trans)
        TR_NONSEQ: begin
          if (own_burst == BU_SINGLE)    rearb = 1'b1;
          else if (own_burst == BU_INCR) incr_beat = 1'b1;
          else begin
            case (own_burst[2:1])
              2'b01:   beat_nxt = 4'd3;
              2'b10:   beat_nxt = 4'd7;
              default: beat_nxt = 4'd15;
            endcase
          end
        end
        TR_SEQ: begin
          if (own_burst == BU_INCR)  incr_beat = 1'b1;
          else if (beat_cnt <= 4'd1) rearb = 1'b1;
          else                       beat_nxt = beat_cnt - 4'd1;
        end
        default: ;
      endcase
      if (limit_hit) rearb = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state        <= ARB_IDLE;
      hgrant       <= '0;
      hmaster_addr <= '0;
      hmaster_data <= '0;
      hdata_valid  <= 1'b0;
      beat_cnt     <= '0;
      last_owner   <= MASTER_IDX_W'(N - 1);
    end else if (hready) begin
      hmaster_data <= hmaster_addr;
      hdata_valid  <= hsel && (own_trans == TR_NONSEQ || own_trans == TR_SEQ);
      if (rearb) begin
        beat_cnt <= '0;
        if (|hreq) begin
          state        <= ARB_OWN;
          hgrant       <= ONE << win_idx;
          hmaster_addr <= win_idx;
          last_owner   <= win_idx;
        end else begin
          state  <= ARB_IDLE;
          hgrant <= '0;
        end
      end else begin
        beat_cnt <= beat_nxt;
      end
    end
  end

`ifdef AHB_ARB_BURST_LIMIT_EN
  always_ff @(posedge hclk) begin
    if (hreset) begin
      hold_cnt <= '0;
    end else if (hready) begin
      if (rearb)                              hold_cnt <= '0;
      else if (incr_beat && hold_cnt != '1)   hold_cnt <= hold_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb/tb_ahb_slave_arbiter.sv - directed plus randomized bench for ahb_slave_arbiter
module tb_ahb_slave_arbiter;
  localparam int N  = 3;
  localparam int W  = 2;
  localparam int MH = 4;
  localparam int IDLE = 0, BUSY = 1, NS = 2, SQ = 3;

  logic           hclk = 1'b0;
  logic           hreset;
  logic [N-1:0]   hreq;
  logic [2*N-1:0] htrans;
  logic [3*N-1:0] hburst;
  logic           hready;
  logic [N-1:0]   hgrant;
  logic [W-1:0]   hmaster_addr;
  logic           hsel;
  logic [W-1:0]   hmaster_data;
  logic           hdata_valid;

  ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(N), .MASTER_IDX_W(W), .MAX_HOLD(MH)) dut (
    .hclk(hclk), .hreset(hreset), .hreq(hreq), .htrans(htrans), .hburst(hburst),
    .hready(hready), .hgrant(hgrant), .hmaster_addr(hmaster_addr), .hsel(hsel),
    .hmaster_data(hmaster_data), .hdata_valid(hdata_valid)
  );

  always #5 hclk = ~hclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner, pointer, remaining beats of a fixed burst, INCR beats so far.
  bit m_own;
  int m_addr, m_last, m_left, m_incr, m_data;
  bit m_dv;

  function automatic int tr_of(int m);
    return int'(htrans[2*m +: 2]);
  endfunction

  function automatic int bu_of(int m);
    return int'(hburst[3*m +: 3]);
  endfunction

  function automatic int burst_beats(int b);
    if (b < 2) return 0;
    return 4 << ((b - 2) / 2);
  endfunction

  function automatic int rr_winner();
    for (int k = 1; k <= N; k++)
      if (hreq[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  function automatic void model_step();
    int t, b, w, others;
    bit rel;
    if (hreset) begin
      m_own = 0; m_addr = 0; m_last = N - 1; m_left = 0; m_incr = 0; m_data = 0; m_dv = 0;
    end else if (hready) begin
      t = tr_of(m_addr);
      b = bu_of(m_addr);
      m_data = m_addr;
      m_dv   = m_own && hreq[m_addr] && t >= NS;
      rel    = !m_own || !hreq[m_addr] || t == IDLE;
      others = int'(hreq) & ~(1 << m_addr);
      if (!rel && t >= NS) begin
        if (b == 0) rel = 1;
        else if (b == 1) begin
          m_incr++;
`ifdef AHB_ARB_BURST_LIMIT_EN
          if (m_incr >= MH && others != 0) rel = 1;
`endif
        end else begin
          if (t == NS) m_left = burst_beats(b);
          m_left--;
          rel = (m_left <= 0);
        end
      end
      if (rel) begin
        m_left = 0;
        m_incr = 0;
        w = rr_winner();
        if (w >= 0) begin m_own = 1; m_addr = w; m_last = w; end
        else m_own = 0;
      end
    end
  endfunction

  always @(posedge hclk) begin
    model_step();
    #1;
    check("hgrant", int'(hgrant), m_own ? (1 << m_addr) : 0);
    check("hmaster_addr", int'(hmaster_addr), m_addr);
    check("hsel", int'(hsel), (m_own && hreq[m_addr]) ? 1 : 0);
    check("hmaster_data", int'(hmaster_data), m_data);
    check("hdata_valid", int'(hdata_valid), m_dv ? 1 : 0);
  end

  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic set_m(int m, bit r, int t, int b);
    hreq[m]           = r;
    htrans[2*m +: 2]  = 2'(t);
    hburst[3*m +: 3]  = 3'(b);
  endtask

  int want[N], rest[N], blen[N], done[N], bty[N];
  int beats, was;
  bit rdy, rst;
  int busy_tbl[6] = '{NS, BUSY, SQ, BUSY, SQ, SQ};

  initial begin
    hreset = 1; hreq = '0; htrans = '0; hburst = '0; hready = 1;
    tick(); tick();
    check("rst_hgrant", int'(hgrant), 0);
    check("rst_addr", int'(hmaster_addr), 0);
    check("rst_hsel", int'(hsel), 0);
    check("rst_data", int'(hmaster_data), 0);
    check("rst_dv", int'(hdata_valid), 0);
    hreset = 0;

    // Two SINGLE requesters alternate.
    set_m(0, 1, NS, 0); set_m(2, 1, NS, 0);
    tick(); check("alt_1", int'(hgrant), 3'b001);
    tick(); check("alt_2", int'(hgrant), 3'b100);
    tick(); check("alt_3", int'(hgrant), 3'b001);

    // INCR4 from master 1 while master 0 keeps requesting.
    set_m(2, 0, IDLE, 0); set_m(1, 1, NS, 3);
    tick(); check("incr4_grant", int'(hgrant), 3'b010);
    for (int k = 0; k < 4; k++) begin
      set_m(1, 1, (k == 0) ? NS : SQ, 3);
      tick();
      check("incr4_hold", int'(hgrant), (k < 3) ? 3'b010 : 3'b001);
      if (k == 0) begin
        check("incr4_dv", int'(hdata_valid), 1);
        check("incr4_data", int'(hmaster_data), 1);
      end
    end
    set_m(0, 0, IDLE, 0); set_m(1, 0, IDLE, 0);
    tick(); check("to_idle", int'(hgrant), 0);

    // INCR8 with three wait states in the middle.
    set_m(0, 1, NS, 0); set_m(2, 1, NS, 5);
    tick(); check("incr8_grant", int'(hgrant), 3'b100);
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      if (hgrant != 3'b100) break;
      hready = !(c >= 2 && c < 5);
      set_m(2, 1, (beats == 0) ? NS : SQ, 5);
      rdy = hready;
      tick();
      if (rdy) beats++;
      else begin
        check("freeze_grant", int'(hgrant), 3'b100);
        check("freeze_addr", int'(hmaster_addr), 2);
      end
    end
    hready = 1;
    check("incr8_beats", beats, 8);
    check("incr8_next", int'(hgrant), 3'b001);

    // INCR4 with two BUSY cycles.
    set_m(0, 0, IDLE, 0); set_m(2, 0, IDLE, 0); set_m(1, 1, NS, 3);
    tick(); check("busy_grant", int'(hgrant), 3'b010);
    set_m(0, 1, NS, 0);
    for (int k = 0; k < 6; k++) begin
      set_m(1, 1, busy_tbl[k], 3);
      tick();
      check("busy_hold", int'(hgrant), (k < 5) ? 3'b010 : 3'b001);
      check("busy_dv", int'(hdata_valid), (busy_tbl[k] >= NS) ? 1 : 0);
    end

    // Reset during beat 2 of WRAP8.
    set_m(1, 1, NS, 4);
    tick(); check("wrap8_grant", int'(hgrant), 3'b010);
    tick();
    set_m(1, 1, SQ, 4); hreset = 1;
    tick();
    check("midrst_grant", int'(hgrant), 0);
    check("midrst_addr", int'(hmaster_addr), 0);
    check("midrst_dv", int'(hdata_valid), 0);
    hreset = 0; set_m(1, 1, NS, 0);
    tick(); check("postrst_first", int'(hgrant), 3'b001);

    // Undefined-length INCR from master 2 with master 0 waiting.
    set_m(0, 0, IDLE, 0); set_m(1, 0, IDLE, 0);
    tick(); check("incr_idle", int'(hgrant), 0);
    set_m(2, 1, NS, 1);
    tick(); check("incr_grant", int'(hgrant), 3'b100);
    set_m(0, 1, NS, 0);
`ifdef AHB_ARB_BURST_LIMIT_EN
    for (int k = 0; k < 4; k++) begin
      set_m(2, 1, (k == 0) ? NS : SQ, 1);
      tick();
      check("limit_hold", int'(hgrant), (k < 3) ? 3'b100 : 3'b001);
    end
`else
    for (int k = 0; k < 8; k++) begin
      set_m(2, 1, (k == 0) ? NS : SQ, 1);
      tick();
      check("incr_hold", int'(hgrant), 3'b100);
    end
    set_m(2, 1, IDLE, 1);
    tick(); check("incr_release", int'(hgrant), 3'b001);
`endif

    // Randomized traffic from protocol-following masters.
    hreset = 1; tick(); hreset = 0;
    for (int m = 0; m < N; m++) begin want[m] = 0; rest[m] = 0; done[m] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int m = 0; m < N; m++) begin
        if (!want[m]) begin
          if (rest[m] > 0) rest[m]--;
          else begin
            want[m] = 1;
            bty[m]  = $urandom_range(0, 7);
            blen[m] = (bty[m] == 0) ? 1 : (bty[m] == 1) ? $urandom_range(1, 6) : burst_beats(bty[m]);
            done[m] = 0;
          end
        end
        if (!want[m]) set_m(m, 0, IDLE, 0);
        else if (m_own && m_addr == m && done[m] > 0)
          set_m(m, 1, ($urandom_range(0, 3) == 0) ? BUSY : SQ, bty[m]);
        else set_m(m, 1, NS, bty[m]);
      end
      hready = ($urandom_range(0, 4) != 0);
      hreset = ($urandom_range(0, 499) == 0);
      was = m_own ? m_addr : -1;
      rdy = hready;
      rst = hreset;
      tick();
      if (rst) begin
        for (int m = 0; m < N; m++) begin want[m] = 0; rest[m] = 0; end
      end else begin
        if (rdy && was >= 0 && want[was] != 0 && tr_of(was) >= NS) done[was]++;
        for (int m = 0; m < N; m++)
          if (want[m] != 0 && done[m] >= blen[m]) begin
            want[m] = 0;
            rest[m] = $urandom_range(0, 3);
          end
      end
    end
    hreset = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Per-slave AHB arbiter that sits directly downstream of the per-master address decoders. It collects the one-hot `hreq` vectors routed to one slave port, grants the slave to one master at a time, and holds the grant for the duration of a burst. It uses round-robin priority and publishes address-phase and data-phase owner indices for the slave-side multiplexers. One instance exists per slave in the generated interconnect.

## Interface
Parameters:
- `SLAVE_X_MASTER_NUM`, default 3: number of masters that can reach this slave; must be ≥ 2.
- `MASTER_IDX_W`, default `$clog2(SLAVE_X_MASTER_NUM)`: width of the owner index.
- `MAX_HOLD`, default 16: beat limit for undefined-length INCR bursts; used only with `AHB_ARB_BURST_LIMIT_EN`.

Ports:
- `hclk`, input, 1: clock. One clock domain; all state updates on the rising edge.
- `hreset`, input, 1: reset, synchronous, active-high.
- `hreq`, input, `SLAVE_X_MASTER_NUM`: bit m is this slave's bit of master m's decoder `hreq`.
- `htrans`, input, `SLAVE_X_MASTER_NUM`×2: per-master `htrans_type`. IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hburst`, input, `SLAVE_X_MASTER_NUM`×3: per-master burst type. SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111.
- `hready`, input, 1: slave ready. A beat is accepted at an edge where `hready`=1.
- `hgrant`, output, `SLAVE_X_MASTER_NUM`: registered one-hot grant, or all-zero.
- `hmaster_addr`, output, `MASTER_IDX_W`: address-phase owner index.
- `hsel`, output, 1: slave select, equal to grant valid AND `hreq[hmaster_addr]`.
- `hmaster_data`, output, `MASTER_IDX_W`: data-phase owner index.
- `hdata_valid`, output, 1: data phase belongs to a granted, selected transfer.

## Operation
- States: `ARB_IDLE` (no owner, `hgrant`=0) and `ARB_OWN` (owner = `hmaster_addr`).
- All state, grant, counter and pointer updates occur only at edges with `hready`=1. With `hready`=0, everything is frozen.
- Winner selection: round-robin search starting at `last_owner+1` modulo N. The previous owner has lowest priority but wins if it is the sole requester. After reset `last_owner`=N-1, so master 0 has highest priority.
- In `ARB_IDLE`: any `hreq` bit set → grant the winner, go to `ARB_OWN`; otherwise stay.
- In `ARB_OWN`, the hold decision uses the owner's `htrans`/`hburst` at the accepting edge:
  - `hreq[owner]`=0 or `htrans`=IDLE → release.
  - NONSEQ with SINGLE → release.
  - NONSEQ with fixed burst (WRAP/INCR 4/8/16) → hold; `beat_cnt` := length−1.
  - SEQ on a fixed burst → `beat_cnt` −1; release when `beat_cnt` was 1 (last beat accepted).
  - NONSEQ/SEQ on INCR → hold; `hold_cnt` +1.
  - BUSY → hold; no counter change.
- Release: if any request is pending → grant the new winner (possibly the same master) and stay in `ARB_OWN`; else go to `ARB_IDLE`.
- `last_owner` updates on every grant change and on every re-grant.
- Data phase: at each `hready`=1 edge, `hmaster_data` := `hmaster_addr` and `hdata_valid` := `hsel` AND owner `htrans` ∈ {NONSEQ, SEQ}.
- Counter widths: `beat_cnt` is 4 bits; `hold_cnt` is `$clog2(MAX_HOLD)+1` bits and saturates.
- Simultaneous requests from all masters in `ARB_IDLE` → the lowest index after the pointer wins; the others wait with no starvation.

## Timing
- Reset values: `hgrant`=0, `hmaster_addr`=0, `hsel`=0, `hmaster_data`=0, `hdata_valid`=0, state `ARB_IDLE`, counters 0, `last_owner`=N-1.
- Reset asserted mid-burst: all outputs return to reset values at that edge. No burst completion is attempted.
- Grant latency: a request sampled at edge t (with `hready`=1) → `hgrant` asserted after edge t.
- Re-arbitration is zero-bubble: the last beat accepted at edge t → the next owner is granted after edge t.
- `hmaster_data` and `hdata_valid` lag `hmaster_addr` by exactly one accepted beat.
- `hsel` is combinational from registered state and `hreq`.

## Configuration
- `AHB_ARB_BURST_LIMIT_EN` defined: in an INCR burst, when `hold_cnt` reaches `MAX_HOLD` accepted beats and another master is requesting, the arbiter releases at that edge. `hold_cnt` clears on every grant change.
- Without the macro: INCR bursts hold until release by IDLE or `hreq` drop; `hold_cnt` logic is absent.

## Test plan
- Reset, then `hreq`=101, both masters issue NONSEQ SINGLE, `hready`=1 → `hgrant`=001, then 100, then 001 (alternating).
- Master 1 issues INCR4 (NONSEQ + 3 SEQ) while master 0 requests → `hgrant`=010 for 4 accepted beats; 001 after the edge accepting the 4th beat.
- `hready`=0 for 3 cycles mid-INCR8 → `hgrant`, `hmaster_addr` and `beat_cnt` unchanged; burst completes with exactly 8 accepted beats.
- INCR4 with 2 BUSY cycles inserted → grant held for 6 accepted edges; `hdata_valid`=0 on BUSY data phases.
- `hreset`=1 during beat 2 of WRAP8 → all outputs 0 after that edge; the next request is granted to master 0 first.
- With `AHB_ARB_BURST_LIMIT_EN` and `MAX_HOLD`=4, master 2 issues INCR and master 0 requests → switch to master 0 after 4 beats. Without the macro, master 2 holds until its `htrans`=IDLE.
